// File: rtl/data_mem_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_unit                                                            |
// | MEM-stage data RAM with byte-lane stores, extending loads and MMIO regs. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_mem_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  memMode,
  output logic [31:0] readData,
  output logic [15:0] led,
  output logic        alignErr,
  output logic [31:0] errAddr
);

  localparam int unsigned c_IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]        r_ram [DEPTH_WORDS];
  logic [15:0]        r_led;
  logic [31:0]        r_cycleCnt;
  logic [31:0]        r_storeCnt;
  logic [31:0]        r_errAddr;
  logic               r_alignErr;

  logic               w_isHalf;
  logic               w_isByte;
  logic               w_isWord;
  logic               w_isSigned;
  logic               w_isMmio;
  logic               w_misaligned;
  logic               w_ramWe;
  logic               w_ledWe;
  logic [c_IDX_W-1:0] w_wordIdx;
  logic [3:0]         w_laneEn;
  logic [31:0]        w_laneData;
  logic [31:0]        w_srcWord;
  logic [31:0]        w_loadVal;
  logic [15:0]        w_half;
  logic [7:0]         w_byte;

  always_comb begin
    w_isHalf     = (memMode == 3'd1) || (memMode == 3'd2);
    w_isByte     = (memMode == 3'd3) || (memMode == 3'd4);
    w_isWord     = !w_isHalf && !w_isByte;
    w_isSigned   = (memMode == 3'd1) || (memMode == 3'd3);
    w_isMmio     = (address[31:4] == MMIO_BASE[31:4]);
    w_misaligned = (w_isWord && (address[1:0] != 2'b00)) || (w_isHalf && address[0]);
  end

  assign w_wordIdx = address[c_IDX_W+1:2];
  // Reset at the edge also drops a pending store; RAM itself is never cleared.
  assign w_ramWe   = memWrite && rst_n && !w_isMmio && !w_misaligned;
  assign w_ledWe   = memWrite && w_isMmio && w_isWord && (address[3:0] == 4'h0);

  always_comb begin
    w_laneEn   = 4'b1111;
    w_laneData = writeData;
    if (w_isByte) begin
      w_laneEn                = 4'b0000;
      w_laneEn[address[1:0]]  = 1'b1;
      w_laneData              = {4{writeData[7:0]}};
    end else if (w_isHalf) begin
      w_laneEn   = address[1] ? 4'b1100 : 4'b0011;
      w_laneData = {2{writeData[15:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (w_ramWe) begin
      for (int k = 0; k < 4; k++) begin
        if (w_laneEn[k]) r_ram[w_wordIdx][8*k +: 8] <= w_laneData[8*k +: 8];
      end
    end
  end

  always_comb begin
    if (w_isMmio) begin
      case (address[3:2])
        2'd0:    w_srcWord = {16'h0000, r_led};
        2'd1:    w_srcWord = r_cycleCnt;
        2'd2:    w_srcWord = r_storeCnt;
        default: w_srcWord = 32'h0000_0000;
      endcase
    end else begin
      w_srcWord = r_ram[w_wordIdx];
    end
    w_half = address[1] ? w_srcWord[31:16] : w_srcWord[15:0];
    case (address[1:0])
      2'd0:    w_byte = w_srcWord[7:0];
      2'd1:    w_byte = w_srcWord[15:8];
      2'd2:    w_byte = w_srcWord[23:16];
      default: w_byte = w_srcWord[31:24];
    endcase
    w_loadVal = w_srcWord;
    if (w_isHalf) begin
      w_loadVal = w_isSigned ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
    end else if (w_isByte) begin
      w_loadVal = w_isSigned ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
    end
    readData = (memRead && !w_misaligned) ? w_loadVal : 32'h0000_0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led      <= '0;
      r_cycleCnt <= '0;
      r_storeCnt <= '0;
      r_alignErr <= 1'b0;
      r_errAddr  <= '0;
    end else begin
      r_cycleCnt <= r_cycleCnt + 32'd1;
      if (w_ramWe) r_storeCnt <= r_storeCnt + 32'd1;
      if (w_ledWe) r_led <= writeData[15:0];
      // Sticky flag; errAddr keeps only the first offending address.
      if ((memRead || memWrite) && w_misaligned) begin
        r_alignErr <= 1'b1;
        if (!r_alignErr) r_errAddr <= address;
      end
    end
  end

  assign led      = r_led;
  assign alignErr = r_alignErr;
  assign errAddr  = r_errAddr;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_mem_unit                                                         |
// | Directed vector table plus randomized accesses against a memory model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_data_mem_unit;

  localparam int unsigned c_DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  memMode;
  logic [31:0] readData;
  logic [15:0] led;
  logic        alignErr;
  logic [31:0] errAddr;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [31:0] mMem [c_DEPTH];
  logic [15:0] mLed;
  logic [31:0] mCycle;
  logic [31:0] mStore;
  logic        mErr;
  logic [31:0] mErrAddr;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  data_mem_unit #(.DEPTH_WORDS(c_DEPTH), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .memMode(memMode),
    .readData(readData), .led(led), .alignErr(alignErr), .errAddr(errAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int accSize(input logic [2:0] mode);
    if (mode == 3'd1 || mode == 3'd2) return 2;
    if (mode == 3'd3 || mode == 3'd4) return 1;
    return 4;
  endfunction

  function automatic bit isIo(input logic [31:0] a);
    return (a >> 4) == (32'hFFFF_0000 >> 4);
  endfunction

  function automatic logic [31:0] modelRead(input logic [2:0] mode, input logic [31:0] a);
    logic [31:0] src;
    logic [31:0] v;
    int sz;
    sz = accSize(mode);
    if ((a % sz) != 0) return 32'h0;
    if (isIo(a)) begin
      case ((a % 16) / 4)
        0:       src = {16'h0, mLed};
        1:       src = mCycle;
        2:       src = mStore;
        default: src = 32'h0;
      endcase
    end else begin
      src = mMem[(a / 4) % c_DEPTH];
    end
    v = src >> (8 * (a % 4));
    case (mode)
      3'd1:    return 32'($signed(v[15:0]));
      3'd2:    return v & 32'h0000_FFFF;
      3'd3:    return 32'($signed(v[7:0]));
      3'd4:    return v & 32'h0000_00FF;
      default: return src;
    endcase
  endfunction

  task automatic modelEdge(input logic rd, input logic wr, input logic [2:0] mode,
                           input logic [31:0] a, input logic [31:0] wd);
    int sz;
    int idx;
    logic [31:0] w;
    sz = accSize(mode);
    if ((rd || wr) && (a % sz) != 0) begin
      if (!mErr) mErrAddr = a;
      mErr = 1'b1;
    end else if (wr) begin
      if (isIo(a)) begin
        if (sz == 4 && (a % 16) == 0) mLed = wd[15:0];
      end else begin
        idx = (a / 4) % c_DEPTH;
        w = mMem[idx];
        for (int b = 0; b < sz; b++) w[8*((a % 4) + b) +: 8] = wd[8*b +: 8];
        mMem[idx] = w;
        mStore = mStore + 1;
      end
    end
    mCycle = mCycle + 1;
  endtask

  task automatic modelReset();
    mLed = '0; mCycle = '0; mStore = '0; mErr = 1'b0; mErrAddr = '0;
  endtask

  // Starts and ends at posedge+1; outputs are sampled at the negedge.
  task automatic step(input logic rd, input logic wr, input logic [2:0] mode,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit useExp, input logic [31:0] exp, input string name,
                      output logic [31:0] got);
    memRead = rd; memWrite = wr; memMode = mode; address = a; writeData = wd;
    @(negedge clk);
    got = readData;
    chk({name, ".readData"}, readData, useExp ? exp : modelRead(rd ? mode : 3'd0, rd ? a : 32'h0) & {32{rd}});
    chk({name, ".led"}, {16'h0, led}, {16'h0, mLed});
    chk({name, ".alignErr"}, {31'h0, alignErr}, {31'h0, mErr});
    chk({name, ".errAddr"}, errAddr, mErrAddr);
    @(posedge clk);
    modelEdge(rd, wr, mode, a, wd);
    #1;
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] mode,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] exp, input string name);
    vec_t v;
    v.rd = rd; v.wr = wr; v.mode = mode; v.addr = a; v.wdata = wd; v.exp = exp; v.name = name;
    return v;
  endfunction

  initial begin
    logic [31:0] got;
    logic [31:0] c1;
    logic [31:0] a;
    logic [2:0]  mode;
    bit          hold;

    rst_n = 1'b0; memRead = 0; memWrite = 0; memMode = 0; address = 0; writeData = 0;
    modelReset();
    for (int i = 0; i < c_DEPTH; i++) mMem[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.led", {16'h0, led}, 32'h0);
    chk("rst.alignErr", {31'h0, alignErr}, 32'h0);
    chk("rst.errAddr", errAddr, 32'h0);
    memRead = 1; address = 32'hFFFF_0004;
    #1 chk("rst.cycleHeld", readData, 32'h0);
    address = 32'hFFFF_0008;
    #1 chk("rst.storeCnt", readData, 32'h0);
    rst_n = 1'b1;
    modelReset();
    step(1, 0, 0, 32'hFFFF_0004, 0, 1, 32'h0, "cyc0", got);
    step(1, 0, 0, 32'hFFFF_0004, 0, 1, 32'h1, "cyc1", got);
    step(1, 0, 0, 32'hFFFF_0004, 0, 1, 32'h2, "cyc2", got);

    vecs.push_back(mk(0, 1, 0, 32'h100, 32'hDEADBEEF, 32'h0,        "st_w100"));
    vecs.push_back(mk(1, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, "ld_w100"));
    vecs.push_back(mk(1, 1, 0, 32'h100, 32'h11111111, 32'hDEADBEEF, "rw_same_cycle"));
    vecs.push_back(mk(1, 0, 0, 32'h100, 32'h0,        32'h11111111, "ld_after_rw"));
    vecs.push_back(mk(0, 1, 0, 32'h200, 32'h80FF7F01, 32'h0,        "st_w200"));
    vecs.push_back(mk(1, 0, 3, 32'h200, 32'h0,        32'h00000001, "lb_200"));
    vecs.push_back(mk(1, 0, 3, 32'h201, 32'h0,        32'h0000007F, "lb_201"));
    vecs.push_back(mk(1, 0, 3, 32'h202, 32'h0,        32'hFFFFFFFF, "lb_202"));
    vecs.push_back(mk(1, 0, 3, 32'h203, 32'h0,        32'hFFFFFF80, "lb_203"));
    vecs.push_back(mk(1, 0, 4, 32'h203, 32'h0,        32'h00000080, "lbu_203"));
    vecs.push_back(mk(1, 0, 1, 32'h202, 32'h0,        32'hFFFF80FF, "lh_202"));
    vecs.push_back(mk(1, 0, 2, 32'h202, 32'h0,        32'h000080FF, "lhu_202"));
    vecs.push_back(mk(1, 0, 1, 32'h200, 32'h0,        32'h00007F01, "lh_200"));
    vecs.push_back(mk(0, 1, 0, 32'h300, 32'h0,        32'h0,        "st_w300"));
    vecs.push_back(mk(1, 0, 0, 32'hFFFF0008, 32'h0,   32'd4,        "scnt_before"));
    vecs.push_back(mk(0, 1, 3, 32'h301, 32'h000000AB, 32'h0,        "sb_301"));
    vecs.push_back(mk(1, 0, 0, 32'h300, 32'h0,        32'h0000AB00, "ld_w300"));
    vecs.push_back(mk(1, 0, 0, 32'hFFFF0008, 32'h0,   32'd5,        "scnt_after"));
    vecs.push_back(mk(0, 1, 2, 32'h306, 32'hCAFE5566, 32'h0,        "sh_306"));
    vecs.push_back(mk(0, 1, 3, 32'h304, 32'hFFFFFF88, 32'h0,        "sb_304"));
    vecs.push_back(mk(1, 0, 0, 32'h304, 32'h0,        32'h55660088, "ld_w304"));
    vecs.push_back(mk(1, 0, 0, 32'h102, 32'h0,        32'h0,        "ld_mis_w102"));
    vecs.push_back(mk(0, 1, 1, 32'h305, 32'h00009999, 32'h0,        "sh_mis_305"));
    vecs.push_back(mk(1, 0, 0, 32'h304, 32'h0,        32'h55660088, "ld_w304_kept"));
    vecs.push_back(mk(1, 0, 0, 32'hFFFF0008, 32'h0,   32'd7,        "scnt_suppr"));
    vecs.push_back(mk(0, 1, 0, 32'hFFFF0000, 32'h1234ABCD, 32'h0,   "st_led"));
    vecs.push_back(mk(1, 0, 0, 32'hFFFF0000, 32'h0,   32'h0000ABCD, "ld_led"));
    vecs.push_back(mk(1, 0, 1, 32'hFFFF0000, 32'h0,   32'hFFFFABCD, "lh_led"));
    vecs.push_back(mk(1, 0, 4, 32'hFFFF0001, 32'h0,   32'h000000AB, "lbu_led1"));
    vecs.push_back(mk(0, 1, 2, 32'hFFFF0000, 32'h00005555, 32'h0,   "sh_led_ign"));
    vecs.push_back(mk(0, 1, 0, 32'hFFFF0004, 32'h0,   32'h0,        "st_cyc_ign"));
    vecs.push_back(mk(1, 0, 0, 32'hFFFF0000, 32'h0,   32'h0000ABCD, "ld_led_kept"));
    vecs.push_back(mk(1, 0, 0, 32'hFFFF000C, 32'h0,   32'h0,        "ld_io_c"));
    vecs.push_back(mk(1, 0, 0, 32'h0001_0100, 32'h0,  32'h11111111, "ld_alias"));

    foreach (vecs[i])
      step(vecs[i].rd, vecs[i].wr, vecs[i].mode, vecs[i].addr, vecs[i].wdata,
           1, vecs[i].exp, vecs[i].name, got);

    chk("err.flag", {31'h0, alignErr}, 32'h1);
    chk("err.firstAddr", errAddr, 32'h0000_0102);

    step(1, 0, 0, 32'hFFFF_0004, 0, 0, 0, "cycA", c1);
    step(0, 0, 0, 32'h0, 0, 0, 0, "cycGap", got);
    step(1, 0, 0, 32'hFFFF_0004, 0, 0, 0, "cycB", got);
    chk("cyc.diff2", got - c1, 32'd2);

    step(0, 1, 0, 32'h400, 32'hAAAA0000, 0, 0, "st_w400", got);
    // Store presented while reset is asserted must be lost.
    memRead = 0; memWrite = 1; memMode = 0; address = 32'h400; writeData = 32'h12345678;
    rst_n = 1'b0;
    #1;
    chk("mrst.led", {16'h0, led}, 32'h0);
    chk("mrst.alignErr", {31'h0, alignErr}, 32'h0);
    chk("mrst.errAddr", errAddr, 32'h0);
    @(posedge clk);
    #1;
    memWrite = 0; memRead = 1; address = 32'hFFFF_0004;
    #1 chk("mrst.cycle", readData, 32'h0);
    address = 32'hFFFF_0008;
    #1 chk("mrst.storeCnt", readData, 32'h0);
    rst_n = 1'b1;
    modelReset();
    step(1, 0, 0, 32'h400, 0, 1, 32'hAAAA0000, "mrst.ramKept", got);
    step(1, 0, 0, 32'h100, 0, 1, 32'h11111111, "mrst.ramKept2", got);

    for (int i = 0; i < 64; i++)
      step(0, 1, 0, i * 4, $urandom, 0, 0, "preload", got);

    for (int i = 0; i < 600; i++) begin
      mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        a = 32'hFFFF_0000 | 32'($urandom_range(0, 15));
      end else begin
        a = (32'($urandom_range(0, 32'h7FFF)) << 16) | 32'($urandom_range(0, 255));
      end
      hold = ($urandom_range(0, 3) == 0);
      step(1'($urandom_range(0, 1)), hold, mode, a, $urandom, 0, 0, "rnd", got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_unit.md
# data_mem_unit

Data-side memory subsystem for the pipelined MIPS CPU, attached directly to the MEM-stage memory port (address, store data, read/write strobes, access mode, load data). Holds a word-organised data RAM with byte-lane stores and sign/zero-extending loads, and a small memory-mapped I/O window with an LED register and free-running counters. Loads are combinational so load data can be captured into the MEM/WB stage register on the same edge. Stores commit on the clock edge.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- MMIO_BASE, 32'hFFFF_0000: base of the I/O window; `address[31:4] == MMIO_BASE[31:4]` selects I/O.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- address  in  32  byte address from the MEM stage.
- writeData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- memRead  in  1  load strobe.
- memWrite  in  1  store strobe.
- memMode  in  3  access mode: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned; 5–7 are treated as word.
- readData  out  32  load result, combinational.
- led  out  16  LED register contents.
- alignErr  out  1  sticky misaligned-access flag.
- errAddr  out  32  address of the first misaligned access since reset.

## Operation
- Byte order is little-endian. Lane k (`address[1:0]==k`) is bits [8k+7:8k] of the word.
- RAM word index is `address[log2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so out-of-range addresses alias modulo the depth.
- RAM contents are not reset. The bench writes each location before reading it.
- Store, word: writes all 4 lanes.
- Store, half: writes writeData[15:0] to lanes {1,0} if address[1]==0, else to lanes {3,2}.
- Store, byte: writes writeData[7:0] to lane address[1:0].
- Load: select the lane(s) using the same rules as stores.
  - Half-signed and byte-signed loads sign-extend to 32 bits.
  - Half-unsigned and byte-unsigned loads zero-extend.
  - Word loads return the full word.
- readData = 0 when memRead = 0.
- Misaligned access: word with address[1:0]≠0, or half with address[0]=1.
  - The store is suppressed and readData = 0.
  - alignErr sets on the next edge.
  - errAddr captures the address only if alignErr was 0, so it holds the first error.
- I/O window, selected by `address[3:0]`. I/O accesses never touch RAM.
  - 0x0 LED register: read/write. Word store writes writeData[15:0]. Reads return {16'b0, led}.
  - 0x4 cycle counter: read-only. Increments every cycle and wraps at 2^32.
  - 0x8 store counter: read-only. Increments on each committed RAM store (not I/O stores, not suppressed stores) and wraps at 2^32.
  - 0xC: reads 0, writes ignored.
- Sub-word I/O loads extract lanes from the register value using the RAM rules. Sub-word I/O stores are ignored. The misaligned check applies to I/O too.
- Writes to read-only registers are ignored without error.

## Timing
- Reset (rst_n low, asynchronous): led=0, alignErr=0, errAddr=0, cycle counter=0, store counter=0.
  - The cycle counter holds 0 while reset is asserted and reads 1 after the first rising edge following deassertion.
- Load latency is 0 cycles: readData follows address/memRead/memMode combinationally from RAM/registers as they stood before the next edge.
- Store latency: commits at the rising edge where memWrite=1. A load of the same address in the same cycle returns the old value; the following cycle returns the new value.
- memRead and memWrite both high: the store commits and readData shows pre-store data.
- Counter read in cycle N returns the pre-edge value, which equals the value visible to any other reader that cycle.
- Reset asserted mid-store: the store is lost if reset arrives before the edge. RAM is never cleared by reset.
- No handshake and no stall output. Every access completes in its cycle.

## Test plan
- Word store 0xDEADBEEF to 0x100, next cycle word load 0x100 -> 0xDEADBEEF. Same-cycle load while storing 0x11111111 returns 0xDEADBEEF; the following cycle returns 0x11111111.
- Store 0x80FF7F01 to 0x200.
  - Byte-signed loads of 0x200..0x203 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - Byte-unsigned load of 0x203 -> 0x00000080.
  - Half-signed 0x202 -> 0xFFFF80FF; half-unsigned 0x202 -> 0x000080FF.
- Byte store 0xAB to 0x301 over word 0 -> word load 0x300 = 0x0000AB00; store counter increments by 1.
- Word load 0x102 and half store to 0x305 -> readData 0, RAM at 0x304 unchanged, alignErr=1, errAddr=0x00000102 (second error does not overwrite).
- Word store 0x1234ABCD to 0xFFFF0000 -> led=0xABCD. Store to 0xFFFF0004 is ignored. Loads from 0xFFFF0004 two cycles apart differ by 2.
- Assert rst_n low mid-run -> led, alignErr, errAddr, both counters = 0 immediately. A previously written RAM word still reads its old value.
